// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg: shared encodings for the pipeline hazard/flush controller.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    PC_RUN     = 2'd0,
    PC_MD_BUSY = 2'd1,
    PC_FLUSH   = 2'd2
  } pc_state_e;

  // Segment register indices, front of the pipe first.
  localparam int SEG_PC     = 0;
  localparam int SEG_IF_ID  = 1;
  localparam int SEG_ID_EX  = 2;
  localparam int SEG_EX_MEM = 3;
  localparam int SEG_MEM_WB = 4;
  localparam int SEG_NUM    = 5;

  localparam int RC_B = 0;
  localparam int RC_A = 1;

  // Register dependence with $0 excluded.
  function automatic logic raw_hit(input logic [4:0] wreg, input logic [4:0] rreg,
                                   input logic ren);
    return ren && (wreg != 5'd0) && (wreg == rreg);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_timer.sv
// ----------------------------------------------------------------------------
// md_timer: loadable down-counter tracking remaining mult/div EX occupancy.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module md_timer (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic [5:0] i_load_val,
  input  logic       i_dec,
  output logic       o_done
);

  logic [5:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= 6'd0;
    end else if (i_clear) begin
      r_cnt <= 6'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 6'd0)) begin
      r_cnt <= r_cnt - 6'd1;
    end
  end

  assign o_done = (r_cnt == 6'd0);

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl: stall/refresh/recode controller for the 5-stage MIPS pipeline.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int DIV_CYCLES  = 33,
  parameter int MULT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_ren,
  input  logic       id_rt_ren,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       ex_rs_ren,
  input  logic       ex_rt_ren,
  input  logic       ex_load,
  input  logic       ex_cp0ren,
  input  logic       ex_regwen,
  input  logic [4:0] ex_wreg,
  input  logic       ex_mult,
  input  logic       ex_div,
  input  logic       wb_regwen,
  input  logic [4:0] wb_wreg,
  input  logic       inst_req,
  input  logic       inst_ok,
  input  logic       data_req,
  input  logic       data_ok,
  input  logic       exc_valid,
  output logic       stall_pc,
  output logic       stall_if_id,
  output logic       stall_id_ex,
  output logic       stall_ex_mem,
  output logic       stall_mem_wb,
  output logic       refresh_if_id,
  output logic       refresh_id_ex,
  output logic       refresh_ex_mem,
  output logic       refresh_mem_wb,
  output logic [1:0] recode_id_ex,
  output logic       md_busy
);

  localparam logic       c_DIV_EN    = (DIV_CYCLES > 1);
  localparam logic       c_MULT_EN   = (MULT_CYCLES > 1);
  localparam logic [5:0] c_DIV_LOAD  = (DIV_CYCLES >= 2)  ? 6'(DIV_CYCLES - 2)  : 6'd0;
  localparam logic [5:0] c_MULT_LOAD = (MULT_CYCLES >= 2) ? 6'(MULT_CYCLES - 2) : 6'd0;

  pc_state_e r_state;
  pc_state_e w_next;

  logic [2:0]           w_depth;
  logic                 w_flush_all;
  logic                 w_issue;
  logic                 w_t_clear;
  logic                 w_t_load;
  logic [5:0]           w_t_val;
  logic                 w_t_dec;
  logic                 w_t_done;
  logic [SEG_NUM-1:0]   w_stall;
  logic [SEG_NUM-1:1]   w_refresh;

  logic w_data_wait;
  logic w_fetch_wait;
  logic w_load_use;
  logic w_issue_div;
  logic w_issue_mult;

  assign w_data_wait  = data_req && !data_ok;
  assign w_fetch_wait = inst_req && !inst_ok;
  assign w_issue_div  = ex_div && c_DIV_EN;
  assign w_issue_mult = ex_mult && c_MULT_EN;
  assign w_load_use   = (ex_load || ex_cp0ren) && ex_regwen &&
                        (raw_hit(ex_wreg, id_rs, id_rs_ren) || raw_hit(ex_wreg, id_rt, id_rt_ren));

  md_timer u_md_timer (
    .clk        (clk),
    .resetn     (resetn),
    .i_clear    (w_t_clear),
    .i_load     (w_t_load),
    .i_load_val (w_t_val),
    .i_dec      (w_t_dec),
    .o_done     (w_t_done)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= PC_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // w_depth is the index of the register that takes the bubble; everything
  // in front of it holds.
  always_comb begin
    w_next      = r_state;
    w_depth     = 3'd0;
    w_flush_all = 1'b0;
    w_issue     = 1'b0;
    w_t_clear   = 1'b0;
    w_t_load    = 1'b0;
    w_t_val     = 6'd0;
    w_t_dec     = 1'b0;

    if (exc_valid) begin
      w_flush_all = 1'b1;
      w_t_clear   = 1'b1;
      w_next      = w_fetch_wait ? PC_FLUSH : PC_RUN;
    end else if (r_state == PC_FLUSH) begin
      w_depth = 3'(SEG_IF_ID);
      if (inst_ok) begin
        w_next = PC_RUN;
      end
    end else if (w_data_wait) begin
      w_depth = 3'(SEG_MEM_WB);
    end else if ((r_state == PC_MD_BUSY) && !w_t_done) begin
      w_depth = 3'(SEG_EX_MEM);
      w_t_dec = 1'b1;
    end else begin
      if (r_state == PC_MD_BUSY) begin
        w_next = PC_RUN;
      end
      if ((r_state == PC_RUN) && (w_issue_div || w_issue_mult)) begin
        w_issue  = 1'b1;
        w_depth  = 3'(SEG_EX_MEM);
        w_t_load = 1'b1;
        w_t_val  = w_issue_div ? c_DIV_LOAD : c_MULT_LOAD;
        w_next   = PC_MD_BUSY;
      end else if (w_load_use) begin
        w_depth = 3'(SEG_ID_EX);
      end else if (w_fetch_wait) begin
        w_depth = 3'(SEG_IF_ID);
      end
    end
  end

  always_comb begin
    w_stall   = '0;
    w_refresh = '0;
    for (int i = 0; i < SEG_NUM; i++) begin
      w_stall[i] = resetn && (3'(i) < w_depth);
    end
    for (int i = 1; i < SEG_NUM; i++) begin
      w_refresh[i] = resetn && (w_flush_all || (3'(i) == w_depth));
    end
  end

  assign stall_pc       = w_stall[SEG_PC];
  assign stall_if_id    = w_stall[SEG_IF_ID];
  assign stall_id_ex    = w_stall[SEG_ID_EX];
  assign stall_ex_mem   = w_stall[SEG_EX_MEM];
  assign stall_mem_wb   = w_stall[SEG_MEM_WB];
  assign refresh_if_id  = w_refresh[SEG_IF_ID];
  assign refresh_id_ex  = w_refresh[SEG_ID_EX];
  assign refresh_ex_mem = w_refresh[SEG_EX_MEM];
  assign refresh_mem_wb = w_refresh[SEG_MEM_WB];

  // A held ID/EX register must pick up the value WB is writing right now.
  assign recode_id_ex[RC_A] = stall_id_ex && !refresh_id_ex && wb_regwen &&
                              raw_hit(wb_wreg, ex_rs, ex_rs_ren);
  assign recode_id_ex[RC_B] = stall_id_ex && !refresh_id_ex && wb_regwen &&
                              raw_hit(wb_wreg, ex_rt, ex_rt_ren);

  assign md_busy = resetn && (w_issue || ((r_state == PC_MD_BUSY) && !exc_valid));

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl: directed vector table plus multi-cycle sequences for pipe_ctrl.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wreg, wb_wreg;
  logic       id_rs_ren, id_rt_ren, ex_rs_ren, ex_rt_ren;
  logic       ex_load, ex_cp0ren, ex_regwen, ex_mult, ex_div, wb_regwen;
  logic       inst_req, inst_ok, data_req, data_ok, exc_valid;
  logic       stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic       refresh_if_id, refresh_id_ex, refresh_ex_mem, refresh_mem_wb;
  logic [1:0] recode_id_ex;
  logic       md_busy;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [11:0] c_ALL  = 12'hFFF;
  localparam logic [11:0] c_NOMD = 12'hFFE;
  // Output vector layout: stall pc..mem_wb, refresh if_id..mem_wb, recode A,B, md_busy
  localparam logic [11:0] c_IDLE  = 12'b00000_0000_00_0;
  localparam logic [11:0] c_LU    = 12'b11000_0100_00_0;
  localparam logic [11:0] c_FW    = 12'b10000_1000_00_0;
  localparam logic [11:0] c_DW    = 12'b11110_0001_00_0;
  localparam logic [11:0] c_MD    = 12'b11100_0010_00_1;
  localparam logic [11:0] c_DW_MD = 12'b11110_0001_00_1;
  localparam logic [11:0] c_EXC   = 12'b00000_1111_00_0;

  always #5 clk = ~clk;

  pipe_ctrl #(.DIV_CYCLES(33), .MULT_CYCLES(2)) dut (
    .clk(clk), .resetn(resetn),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_ren(id_rs_ren), .id_rt_ren(id_rt_ren),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rs_ren(ex_rs_ren), .ex_rt_ren(ex_rt_ren),
    .ex_load(ex_load), .ex_cp0ren(ex_cp0ren), .ex_regwen(ex_regwen), .ex_wreg(ex_wreg),
    .ex_mult(ex_mult), .ex_div(ex_div), .wb_regwen(wb_regwen), .wb_wreg(wb_wreg),
    .inst_req(inst_req), .inst_ok(inst_ok), .data_req(data_req), .data_ok(data_ok),
    .exc_valid(exc_valid),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
    .refresh_if_id(refresh_if_id), .refresh_id_ex(refresh_id_ex),
    .refresh_ex_mem(refresh_ex_mem), .refresh_mem_wb(refresh_mem_wb),
    .recode_id_ex(recode_id_ex), .md_busy(md_busy)
  );

  logic [11:0] w_obs;
  assign w_obs = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
                  refresh_if_id, refresh_id_ex, refresh_ex_mem, refresh_mem_wb,
                  recode_id_ex, md_busy};

  typedef struct {
    string      name;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt;
    logic [3:0] ren;   // {id_rs, id_rt, ex_rs, ex_rt}
    logic [2:0] prod;  // {load, cp0ren, regwen}
    logic [4:0] ex_wreg;
    logic       wb_regwen;
    logic [4:0] wb_wreg;
    logic [4:0] ctl;   // {inst_req, inst_ok, data_req, data_ok, exc_valid}
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[22];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [11:0] exp, input logic [11:0] mask);
    #1;
    n_total++;
    if ((w_obs & mask) === (exp & mask)) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b required %b (mask %b)", name, w_obs & mask, exp & mask, mask);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0; ex_wreg = 5'd0; wb_wreg = 5'd0;
    id_rs_ren = 1'b0; id_rt_ren = 1'b0; ex_rs_ren = 1'b0; ex_rt_ren = 1'b0;
    ex_load = 1'b0; ex_cp0ren = 1'b0; ex_regwen = 1'b0; ex_mult = 1'b0; ex_div = 1'b0;
    wb_regwen = 1'b0; inst_req = 1'b0; inst_ok = 1'b0; data_req = 1'b0; data_ok = 1'b0;
    exc_valid = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    id_rs = v.id_rs; id_rt = v.id_rt; ex_rs = v.ex_rs; ex_rt = v.ex_rt;
    {id_rs_ren, id_rt_ren, ex_rs_ren, ex_rt_ren} = v.ren;
    {ex_load, ex_cp0ren, ex_regwen} = v.prod;
    ex_wreg = v.ex_wreg; wb_regwen = v.wb_regwen; wb_wreg = v.wb_wreg;
    {inst_req, inst_ok, data_req, data_ok, exc_valid} = v.ctl;
    ex_mult = 1'b0; ex_div = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //               name            idrs idrt exrs exrt ren      prod    wreg wbw wbreg ctl       exp
    vecs[0]  = '{"idle",           5'd0, 5'd0, 5'd0, 5'd0, 4'b0000, 3'b000, 5'd0, 1'b0, 5'd0, 5'b00000, c_IDLE};
    vecs[1]  = '{"lu_rs",          5'd4, 5'd0, 5'd0, 5'd0, 4'b1000, 3'b101, 5'd4, 1'b0, 5'd0, 5'b00000, c_LU};
    vecs[2]  = '{"lu_rt_noren",    5'd0, 5'd4, 5'd0, 5'd0, 4'b1000, 3'b101, 5'd4, 1'b0, 5'd0, 5'b00000, c_IDLE};
    vecs[3]  = '{"lu_r0",          5'd0, 5'd0, 5'd0, 5'd0, 4'b1100, 3'b101, 5'd0, 1'b0, 5'd0, 5'b00000, c_IDLE};
    vecs[4]  = '{"cp0_rt",         5'd0, 5'd9, 5'd0, 5'd0, 4'b0100, 3'b011, 5'd9, 1'b0, 5'd0, 5'b00000, c_LU};
    vecs[5]  = '{"load_nowen",     5'd4, 5'd0, 5'd0, 5'd0, 4'b1000, 3'b100, 5'd4, 1'b0, 5'd0, 5'b00000, c_IDLE};
    vecs[6]  = '{"fetch_wait",     5'd0, 5'd0, 5'd0, 5'd0, 4'b0000, 3'b000, 5'd0, 1'b0, 5'd0, 5'b10000, c_FW};
    vecs[7]  = '{"fetch_ok",       5'd0, 5'd0, 5'd0, 5'd0, 4'b0000, 3'b000, 5'd0, 1'b0, 5'd0, 5'b11000, c_IDLE};
    vecs[8]  = '{"lu_and_fetch",   5'd4, 5'd0, 5'd0, 5'd0, 4'b1000, 3'b101, 5'd4, 1'b0, 5'd0, 5'b10000, c_LU};
    vecs[9]  = '{"data_wait",      5'd0, 5'd0, 5'd0, 5'd0, 4'b0000, 3'b000, 5'd0, 1'b0, 5'd0, 5'b00100, c_DW};
    vecs[10] = '{"data_ok",        5'd0, 5'd0, 5'd0, 5'd0, 4'b0000, 3'b000, 5'd0, 1'b0, 5'd0, 5'b00110, c_IDLE};
    vecs[11] = '{"recode_a",       5'd0, 5'd0, 5'd7, 5'd0, 4'b0010, 3'b000, 5'd0, 1'b1, 5'd7, 5'b00100, 12'b11110_0001_10_0};
    vecs[12] = '{"recode_wb0",     5'd0, 5'd0, 5'd7, 5'd0, 4'b0010, 3'b000, 5'd0, 1'b1, 5'd0, 5'b00100, c_DW};
    vecs[13] = '{"recode_ab",      5'd0, 5'd0, 5'd3, 5'd3, 4'b0011, 3'b000, 5'd0, 1'b1, 5'd3, 5'b00100, 12'b11110_0001_11_0};
    vecs[14] = '{"recode_b",       5'd0, 5'd0, 5'd5, 5'd3, 4'b0011, 3'b000, 5'd0, 1'b1, 5'd3, 5'b00100, 12'b11110_0001_01_0};
    vecs[15] = '{"recode_nostall", 5'd0, 5'd0, 5'd7, 5'd0, 4'b0010, 3'b000, 5'd0, 1'b1, 5'd7, 5'b00000, c_IDLE};
    vecs[16] = '{"recode_wb_off",  5'd0, 5'd0, 5'd7, 5'd0, 4'b0010, 3'b000, 5'd0, 1'b0, 5'd7, 5'b00100, c_DW};
    vecs[17] = '{"exc_over_dwait", 5'd0, 5'd0, 5'd0, 5'd0, 4'b0000, 3'b000, 5'd0, 1'b0, 5'd0, 5'b00101, c_EXC};
    vecs[18] = '{"exc_fetch_ok",   5'd0, 5'd0, 5'd0, 5'd0, 4'b0000, 3'b000, 5'd0, 1'b0, 5'd0, 5'b11001, c_EXC};
    vecs[19] = '{"run_after_exc",  5'd0, 5'd0, 5'd0, 5'd0, 4'b0000, 3'b000, 5'd0, 1'b0, 5'd0, 5'b00000, c_IDLE};
    vecs[20] = '{"dw_over_lu",     5'd4, 5'd0, 5'd0, 5'd0, 4'b1000, 3'b101, 5'd4, 1'b0, 5'd0, 5'b10100, c_DW};
    vecs[21] = '{"recode_lu_only", 5'd4, 5'd0, 5'd4, 5'd0, 4'b1010, 3'b101, 5'd4, 1'b1, 5'd4, 5'b00000, c_LU};

    // Reset with every cause active: outputs must stay low.
    idle();
    resetn = 1'b0;
    data_req = 1'b1; exc_valid = 1'b1; inst_req = 1'b1; ex_div = 1'b1;
    tick(); check("reset_0", c_IDLE, c_ALL);
    tick(); check("reset_1", c_IDLE, c_ALL);
    tick(); idle(); resetn = 1'b1; check("reset_release", c_IDLE, c_ALL);

    for (int i = 0; i < 22; i++) begin
      tick();
      apply(vecs[i]);
      check(vecs[i].name, vecs[i].exp, c_ALL);
    end

    // Load-use lasts one cycle once the load moves on.
    tick(); apply(vecs[1]); check("lw_use_stall", c_LU, c_ALL);
    tick(); ex_load = 1'b0; ex_regwen = 1'b0; check("lw_use_next", c_IDLE, c_ALL);

    // Divide: 32 stalled cycles, cycle 33 runs.
    tick(); idle(); ex_div = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      check("div_busy", c_MD, c_ALL);
      tick();
    end
    check("div_c33", c_IDLE, c_NOMD);
    tick(); ex_div = 1'b0; check("div_done", c_IDLE, c_ALL);

    // Multiply: issue stall only, then the final cycle runs.
    tick(); ex_mult = 1'b1; check("mult_issue", c_MD, c_ALL);
    tick(); check("mult_last", c_IDLE, c_NOMD);
    tick(); ex_mult = 1'b0; check("mult_done", c_IDLE, c_ALL);

    // Data wait freezes the divide count.
    tick(); ex_div = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      check("dwdiv_pre", c_MD, c_ALL);
      tick();
    end
    for (int c = 11; c <= 14; c++) begin
      data_req = 1'b1;
      check("dwdiv_wait", c_DW_MD, c_ALL);
      tick();
    end
    data_req = 1'b0;
    for (int c = 15; c <= 36; c++) begin
      check("dwdiv_post", c_MD, c_ALL);
      tick();
    end
    check("dwdiv_end", c_IDLE, c_NOMD);
    tick(); ex_div = 1'b0; check("dwdiv_done", c_IDLE, c_ALL);

    // Exception on cycle 5 of a divide with a fetch outstanding.
    tick(); ex_div = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      check("excdiv_pre", c_MD, c_ALL);
      tick();
    end
    exc_valid = 1'b1; inst_req = 1'b1; inst_ok = 1'b0;
    check("excdiv_flush", c_EXC, c_ALL);
    tick(); exc_valid = 1'b0; ex_div = 1'b0; check("flush_c6", c_FW, c_ALL);
    tick(); data_req = 1'b1; check("flush_c7_dwait", c_FW, c_ALL);
    tick(); data_req = 1'b0; inst_ok = 1'b1; check("flush_c8_ok", c_FW, c_ALL);
    tick(); inst_req = 1'b0; inst_ok = 1'b0; check("flush_run", c_IDLE, c_ALL);

    // Reset in the middle of a divide returns to RUN.
    tick(); ex_div = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      check("rstdiv_pre", c_MD, c_ALL);
      tick();
    end
    resetn = 1'b0; check("rstdiv_hold0", c_IDLE, c_ALL);
    tick(); check("rstdiv_hold1", c_IDLE, c_ALL);
    tick(); resetn = 1'b1; ex_div = 1'b0; check("rstdiv_release", c_IDLE, c_ALL);
    tick(); inst_req = 1'b1; check("rstdiv_fetch", c_FW, c_ALL);
    tick(); idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
